// File: rtl/seq_detect_param.sv
// seq_detect_param: parametrised serial bit-pattern detector.
// Tracks the last PAT_LEN-1 bits (hist) and how many bits have been consumed
// since reset or since the last non-overlapping match (fill). A match is
// {hist, in} == PATTERN with a full history window. Matches drive out (Mealy
// or Moore timing) and a saturating match counter.
module seq_detect_param #(
  parameter int                   PAT_LEN = 4,
  parameter logic [PAT_LEN-1:0]   PATTERN = 4'b1001,
  parameter int                   OVERLAP = 1,
  parameter int                   MOORE   = 0,
  parameter int                   CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             in,
  output logic             out,
  output logic [CNT_W-1:0] match_cnt,
  output logic             cnt_sat
);

  // fill only has to reach PAT_LEN-1, so clog2(PAT_LEN) bits are enough
  localparam int             FW       = (PAT_LEN > 2) ? $clog2(PAT_LEN) : 1;
  localparam logic [FW-1:0]  FILL_MAX = FW'(PAT_LEN - 1);

  // Catch illegal configurations at elaboration time
  if (PAT_LEN < 2 || PAT_LEN > 32) begin : g_bad_len
    $error("seq_detect_param: PAT_LEN must be in 2..32");
  end
  if (CNT_W < 1) begin : g_bad_cnt
    $error("seq_detect_param: CNT_W must be at least 1");
  end

  logic [PAT_LEN-2:0] hist;
  logic [FW-1:0]      fill;
  logic [PAT_LEN-1:0] cand;
  logic               hit;

  // Candidate word and match qualifier. fill masks stale history after reset
  // and after a non-overlapping match.
  always_comb begin
    cand = {hist, in};
    hit  = en && (cand == PATTERN) && (fill == FILL_MAX);
  end

  // History shift and fill tracking; both hold while en is low
  always_ff @(posedge clk) begin
    if (rst) begin
      hist <= '0;
      fill <= '0;
    end else if (en) begin
      hist <= cand[PAT_LEN-2:0];
      if (hit && (OVERLAP == 0))
        fill <= '0;
      else if (fill != FILL_MAX)
        fill <= fill + FW'(1);
    end
  end

  // Saturating match counter; rst wins over a same-edge hit
  always_ff @(posedge clk) begin
    if (rst)
      match_cnt <= '0;
    else if (hit && !cnt_sat)
      match_cnt <= match_cnt + CNT_W'(1);
  end

  // Saturation flag is purely a decode of the counter register
  always_comb cnt_sat = &match_cnt;

  if (MOORE != 0) begin : g_moore
    logic out_q;
    // Registered output: one-cycle pulse following each sampling edge with a hit
    always_ff @(posedge clk) begin
      if (rst) out_q <= 1'b0;
      else     out_q <= hit;
    end
    assign out = out_q;
  end else begin : g_mealy
    // Combinational output: high while the final pattern bit is presented
    assign out = hit;
  end

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed bench for seq_detect_param. Four instances share one stimulus
// stream: defaults, non-overlapping, Moore with pattern 1101, and a 2-bit
// saturating counter. Each step checks only the instance(s) it targets.
module tb_seq_detect_param;

  logic clk = 1'b0;
  logic rst, en, in;

  logic       out_def, out_nov, out_moo, out_sat;
  logic [7:0] cnt_def, cnt_nov, cnt_moo;
  logic [1:0] cnt_sat2;
  logic       sat_def, sat_nov, sat_moo, sat_sat;

  int nvec = 0;
  int nerr = 0;

  always #10 clk = ~clk;

  seq_detect_param u_def (
    .clk(clk), .rst(rst), .en(en), .in(in),
    .out(out_def), .match_cnt(cnt_def), .cnt_sat(sat_def));

  seq_detect_param #(.OVERLAP(0)) u_nov (
    .clk(clk), .rst(rst), .en(en), .in(in),
    .out(out_nov), .match_cnt(cnt_nov), .cnt_sat(sat_nov));

  seq_detect_param #(.PATTERN(4'b1101), .MOORE(1)) u_moo (
    .clk(clk), .rst(rst), .en(en), .in(in),
    .out(out_moo), .match_cnt(cnt_moo), .cnt_sat(sat_moo));

  seq_detect_param #(.CNT_W(2), .OVERLAP(1)) u_sat (
    .clk(clk), .rst(rst), .en(en), .in(in),
    .out(out_sat), .match_cnt(cnt_sat2), .cnt_sat(sat_sat));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp)
    else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one bit: change inputs on the falling edge, settle 5 units
  task automatic drive(input logic b, input logic e);
    @(negedge clk);
    rst = 1'b0;
    en  = e;
    in  = b;
    #5;
  endtask

  // Just after the sampling edge
  task automatic post();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst = 1'b1;
    en  = 1'b1;
    in  = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic [9:0]  s1   = 10'b0100101001;
  logic [9:0]  o1   = 10'b0000100001;
  logic [6:0]  s2   = 7'b1001001;
  logic [6:0]  o2a  = 7'b0001001;
  logic [6:0]  o2n  = 7'b0001000;
  logic [7:0]  s3   = 8'b01101101;
  logic [7:0]  o3   = 8'b00001001;
  logic [15:0] s6   = 16'b1001001001001001;
  logic [15:0] o6   = 16'b0001001001001001;

  initial begin
    rst = 1'b1; en = 1'b1; in = 1'b0;

    // 1: reset state, then 0100101001 on default config
    do_reset(2);
    chk("rst_cnt", 32'(cnt_def), 32'd0);
    chk("rst_sat", 32'(sat_def), 32'd0);
    chk("rst_out", 32'(out_def), 32'd0);
    chk("rst_moore_out", 32'(out_moo), 32'd0);
    for (int i = 9; i >= 0; i--) begin
      drive(s1[i], 1'b1);
      chk($sformatf("t1_out_bit%0d", 10 - i), 32'(out_def), 32'(o1[i]));
      post();
    end
    chk("t1_cnt", 32'(cnt_def), 32'd2);

    // 2: overlap vs non-overlap on 1001001
    do_reset(1);
    for (int i = 6; i >= 0; i--) begin
      drive(s2[i], 1'b1);
      chk($sformatf("t2_ovl_out_bit%0d", 7 - i), 32'(out_def), 32'(o2a[i]));
      chk($sformatf("t2_nov_out_bit%0d", 7 - i), 32'(out_nov), 32'(o2n[i]));
      post();
    end
    chk("t2_ovl_cnt", 32'(cnt_def), 32'd2);
    chk("t2_nov_cnt", 32'(cnt_nov), 32'd1);

    // 3: Moore, pattern 1101, stream 01101101; out seen just after each edge
    do_reset(1);
    for (int i = 7; i >= 0; i--) begin
      drive(s3[i], 1'b1);
      post();
      chk($sformatf("t3_moore_out_edge%0d", 8 - i), 32'(out_moo), 32'(o3[i]));
    end
    drive(1'b0, 1'b0);
    post();
    chk("t3_moore_out_drop", 32'(out_moo), 32'd0);
    chk("t3_moore_cnt", 32'(cnt_moo), 32'd2);

    // 4: enable gaps inside a 1001
    do_reset(1);
    drive(1'b1, 1'b1); chk("t4_out_a", 32'(out_def), 32'd0); post();
    drive(1'b0, 1'b1); chk("t4_out_b", 32'(out_def), 32'd0); post();
    drive(1'b1, 1'b0); chk("t4_gap1", 32'(out_def), 32'd0); post();
    drive(1'b1, 1'b0); chk("t4_gap2", 32'(out_def), 32'd0); post();
    drive(1'b0, 1'b0); chk("t4_gap3", 32'(out_def), 32'd0); post();
    drive(1'b0, 1'b1); chk("t4_out_c", 32'(out_def), 32'd0); post();
    drive(1'b1, 1'b1); chk("t4_out_final", 32'(out_def), 32'd1); post();
    chk("t4_cnt", 32'(cnt_def), 32'd1);

    // 5: reset in the middle of a pattern, rst wins over a would-be hit
    do_reset(1);
    drive(1'b1, 1'b1); post();
    drive(1'b0, 1'b1); post();
    drive(1'b0, 1'b1); post();
    @(negedge clk); rst = 1'b1; in = 1'b1; en = 1'b1;
    post();
    chk("t5_cnt_after_rst", 32'(cnt_def), 32'd0);
    drive(1'b1, 1'b1); chk("t5_out_after_rst", 32'(out_def), 32'd0); post();
    chk("t5_cnt_still0", 32'(cnt_def), 32'd0);
    drive(1'b1, 1'b1); post();
    drive(1'b0, 1'b1); post();
    drive(1'b0, 1'b1); post();
    drive(1'b1, 1'b1); chk("t5_out_match", 32'(out_def), 32'd1); post();
    chk("t5_cnt", 32'(cnt_def), 32'd1);

    // 6: 2-bit counter saturation across five overlapping matches
    do_reset(1);
    begin
      int cexp = 0;
      for (int i = 15; i >= 0; i--) begin
        drive(s6[i], 1'b1);
        chk($sformatf("t6_out_bit%0d", 16 - i), 32'(out_sat), 32'(o6[i]));
        post();
        if (o6[i] && cexp < 3) cexp++;
        chk($sformatf("t6_cnt_bit%0d", 16 - i), 32'(cnt_sat2), 32'(cexp));
        chk($sformatf("t6_sat_bit%0d", 16 - i), 32'(sat_sat), (cexp == 3) ? 32'd1 : 32'd0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/seq_detect_param.md
Name: seq_detect_param

Overview:
- Parametrised serial bit-pattern detector; successor to the fixed 1001 Mealy detector.
- Supports:
  - any pattern of length PAT_LEN (MSB received first);
  - overlapping or non-overlapping detection;
  - Mealy or Moore output timing;
  - sample-enable qualifier;
  - saturating match counter.
- Sits on a serial data path; its output feeds control/status logic.

Parameters:
PAT_LEN, 4, pattern length in bits; legal range 2..32.
PATTERN, 4'b1001, PAT_LEN-bit target; bit PAT_LEN-1 is the earliest received bit.
OVERLAP, 1, 1 = overlapping matches allowed; 0 = bits of a match cannot be reused.
MOORE, 0, 0 = Mealy (combinational out); 1 = Moore (registered out).
CNT_W, 8, width of match counter.

Ports:
clk  input  1  rising-edge clock; only clock.
rst  input  1  synchronous, active-high reset.
en  input  1  sample qualifier; in is consumed only on edges where en=1.
in  input  1  serial data bit.
out  output  1  match indication; timing per MOORE.
match_cnt  output  CNT_W  number of matches since reset, saturating.
cnt_sat  output  1  high while match_cnt is all-ones.

Behaviour:
- Reset: synchronous, active-high (rst=1 at a rising clk edge). Clears:
  - hist (PAT_LEN-1 bit history);
  - fill (bits consumed since reset/last match, saturates at PAT_LEN-1);
  - registered out (Moore);
  - match_cnt to 0; cnt_sat to 0.
- Reset dominance: rst overrides en and in on the same edge; no match is counted on that edge.
- Candidate word: cand = {hist, in}.
- hit = en && (cand == PATTERN) && (fill == PAT_LEN-1).
- On each edge with en=1 and rst=0:
  - hist shifts left, taking in as its LSB.
  - If hit and OVERLAP=0: fill <- 0.
  - Otherwise: fill <- min(fill+1, PAT_LEN-1).
- On edges with en=0: hist, fill and match_cnt hold; no match is possible.
- Mealy output (MOORE=0): out = hit, combinational. High during the cycle in which the final pattern bit is presented; low when en=0.
- Moore output (MOORE=1): out is registered.
  - out <- hit on every edge, cleared by rst.
  - Stays high exactly one cycle after the sampling edge.
  - Goes low after one cycle unless another hit occurs.
- Counter: on each edge with hit=1, match_cnt increments; it holds at 2^CNT_W-1 once reached.
- cnt_sat = &match_cnt, combinational from the register.
- Overlap example, pattern 1001, stream 1001001:
  - OVERLAP=1 gives 2 matches (last bit of the first match is reused).
  - OVERLAP=0 gives 1 match; a new match needs PAT_LEN fresh bits.
- Start-up: no match before PAT_LEN bits have been consumed since reset. hist contents are masked by fill.
- Synthesis: fully synchronous, no latches. FSM-equivalent state is (hist, fill). An explicit state-encoding FSM is not required.

Test Plan:
1. Defaults, en=1, rst held for 2 cycles, then in = 0,1,0,0,1,0,1,0,0,1 at 20-unit steps (one bit per clk):
   - out high only while the 5th and 10th bits are presented;
   - match_cnt = 2 at the end.
2. OVERLAP=1 vs OVERLAP=0, stream 1,0,0,1,0,0,1:
   - OVERLAP=1: out pulses on bits 4 and 7, match_cnt = 2;
   - OVERLAP=0: pulse on bit 4 only, match_cnt = 1.
3. MOORE=1, PATTERN=4'b1101, stream 0,1,1,0,1,1,0,1:
   - out high for exactly one cycle after the edges sampling bits 5 and 8 (overlap);
   - out low elsewhere; match_cnt = 2.
4. Enable gaps: pattern 1001, feed 1,0 with en=1; then en=0 for 3 cycles with in toggling 1,1,0; then 0,1 with en=1:
   - exactly one match, on the final bit;
   - out stays 0 throughout the en=0 cycles.
5. Reset mid-pattern: feed 1,0,0; assert rst for 1 cycle with in=1; then feed 1:
   - no match, match_cnt stays 0;
   - a subsequent full 1,0,0,1 yields a match and match_cnt = 1.
6. Saturation: CNT_W=2, OVERLAP=1, stream 1001001001001001 (5 matches):
   - match_cnt sequence is 1,2,3,3,3;
   - cnt_sat rises with the 3rd match and stays high;
   - out still pulses on all 5 matches.
